// File: rtl/rv32_pipeline_pkg.sv
// Shared types for the RV32 pipeline memory arbiter: FSM state, bus owner and the latched request.
package rv32_pipeline_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_t;

  typedef struct packed {
    word_t      addr;
    logic       we;
    word_t      wdata;
    logic [3:0] wstrb;
  } mem_req_t;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_DM = 1;

  // A fetch never writes, so its write enable, data and strobes are all zero.
  function automatic mem_req_t fetch_req(input word_t addr);
    mem_req_t req;
    req.addr  = addr;
    req.we    = 1'b0;
    req.wdata = 32'h0000_0000;
    req.wstrb = 4'h0;
    return req;
  endfunction

endpackage

// File: rtl/rv32_arb_grant.sv
// Priority select between fetch and data requests; data wins unless the optional starve guard
// (macro RV32_ARB_STARVE_GUARD_EN) has counted STARVE_LIMIT data grants past a waiting fetch.
module rv32_arb_grant
  import rv32_pipeline_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
`ifdef RV32_ARB_STARVE_GUARD_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic       i_grant_en,
  input  logic       i_if_valid,
  input  logic       i_dm_valid,
  output logic [1:0] o_grant
);

  logic w_force_if;

`ifdef RV32_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_if = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Count data grants that bypassed a pending fetch; any fetch grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (o_grant[GNT_IF]) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (o_grant[GNT_DM] && i_if_valid) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1'b1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // One-hot grant, only while the arbiter is free.
  always_comb begin
    o_grant = 2'b00;
    if (i_grant_en) begin
      if (i_dm_valid && !(w_force_if && i_if_valid)) begin
        o_grant[GNT_DM] = 1'b1;
      end else if (i_if_valid) begin
        o_grant[GNT_IF] = 1'b1;
      end else begin
        o_grant = 2'b00;
      end
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and load/store, one transaction at a time.
// Optional fetch anti-starvation is enabled with macro RV32_ARB_STARVE_GUARD_EN.
module rv32_mem_arbiter
  import rv32_pipeline_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              dm_req_valid,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic              dm_req_we,
  input  logic [31:0]       dm_req_wdata,
  input  logic [3:0]        dm_req_wstrb,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [31:0]       dm_rsp_data,
  output logic              bus_req_valid,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_we,
  output logic [31:0]       bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_req_ready,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_data
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  arb_owner_t r_owner;
  mem_req_t   r_req;
  logic       r_bus_valid;
  logic       r_if_rsp_valid;
  logic       r_dm_rsp_valid;
  word_t      r_if_rsp_data;
  word_t      r_dm_rsp_data;
  logic [1:0] w_grant;
  logic       w_bus_hs;
  logic       w_rsp_done;

  rv32_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
`ifdef RV32_ARB_STARVE_GUARD_EN
    .clk        (clk),
    .rst_n      (rst_n),
`endif
    .i_grant_en (r_state == ARB_IDLE),
    .i_if_valid (if_req_valid),
    .i_dm_valid (dm_req_valid),
    .o_grant    (w_grant)
  );

  assign if_req_ready = w_grant[GNT_IF];
  assign dm_req_ready = w_grant[GNT_DM];
  assign w_bus_hs     = (r_state == ARB_REQ) && r_bus_valid && bus_req_ready;
  assign w_rsp_done   = (r_state == ARB_RSP) && bus_rsp_valid;

  // Next-state decode; stray bus responses outside RSP are ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (|w_grant) w_state_nxt = ARB_REQ;
        else          w_state_nxt = ARB_IDLE;
      end
      ARB_REQ: begin
        if (w_bus_hs) w_state_nxt = ARB_RSP;
        else          w_state_nxt = ARB_REQ;
      end
      ARB_RSP: begin
        if (w_rsp_done) w_state_nxt = ARB_IDLE;
        else            w_state_nxt = ARB_RSP;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Latch the granted request and owner; bus valid holds until the bus takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req       <= {$bits(mem_req_t){1'b0}};
      r_owner     <= OWN_NONE;
      r_bus_valid <= 1'b0;
    end else if (w_grant[GNT_DM]) begin
      r_req       <= '{addr: word_t'(dm_req_addr), we: dm_req_we,
                       wdata: dm_req_wdata, wstrb: dm_req_wstrb};
      r_owner     <= OWN_DM;
      r_bus_valid <= 1'b1;
    end else if (w_grant[GNT_IF]) begin
      r_req       <= fetch_req(word_t'(if_req_addr));
      r_owner     <= OWN_IF;
      r_bus_valid <= 1'b1;
    end else if (w_bus_hs) begin
      r_bus_valid <= 1'b0;
    end else if (w_rsp_done) begin
      r_owner     <= OWN_NONE;
    end else begin
      r_bus_valid <= r_bus_valid;
    end
  end

  // Route the bus response to its owner as a one-cycle pulse; stores return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      r_if_rsp_data  <= 32'h0000_0000;
      r_dm_rsp_data  <= 32'h0000_0000;
    end else begin
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      if (w_rsp_done && (r_owner == OWN_IF)) begin
        r_if_rsp_valid <= 1'b1;
        r_if_rsp_data  <= bus_rsp_data;
      end else if (w_rsp_done && (r_owner == OWN_DM)) begin
        r_dm_rsp_valid <= 1'b1;
        r_dm_rsp_data  <= r_req.we ? 32'h0000_0000 : bus_rsp_data;
      end else begin
        r_if_rsp_data  <= r_if_rsp_data;
        r_dm_rsp_data  <= r_dm_rsp_data;
      end
    end
  end

  assign bus_req_valid = r_bus_valid;
  assign bus_req_addr  = r_req.addr[ADDR_W-1:0];
  assign bus_req_we    = r_req.we;
  assign bus_req_wdata = r_req.wdata;
  assign bus_req_wstrb = r_req.wstrb;
  assign if_rsp_valid  = r_if_rsp_valid;
  assign if_rsp_data   = r_if_rsp_data;
  assign dm_rsp_valid  = r_dm_rsp_valid;
  assign dm_rsp_data   = r_dm_rsp_data;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Honours RV32_ARB_STARVE_GUARD_EN when the design is built with it.
module tb_rv32_mem_arbiter;

  localparam int LIM = 2;
  localparam bit GUARD =
`ifdef RV32_ARB_STARVE_GUARD_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        dm_req_valid, dm_req_we, dm_req_ready, dm_rsp_valid;
  logic [31:0] dm_req_addr, dm_req_wdata, dm_rsp_data;
  logic [3:0]  dm_req_wstrb;
  logic        bus_req_valid, bus_req_we, bus_req_ready, bus_rsp_valid;
  logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_data;
  logic [3:0]  bus_req_wstrb;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_we(dm_req_we),
    .dm_req_wdata(dm_req_wdata), .dm_req_wstrb(dm_req_wstrb), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .bus_req_valid(bus_req_valid), .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb), .bus_req_ready(bus_req_ready),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: one outstanding request, bus handshake, then a response pulse.
  bit          m_busy, m_hs, m_own_dm, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  bit          e_if_p, e_dm_p;
  logic [31:0] e_if_d, e_dm_d;
  int          m_starve;
  bit          g_if, g_dm;
  byte         q_gnt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_hs = 1'b0; e_if_p = 1'b0; e_dm_p = 1'b0; m_starve = 0;
    g_if = 1'b0; g_dm = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    g_dm = 1'b0;
    g_if = 1'b0;
    if (!m_busy) begin
      if (dm_req_valid && !(GUARD && (m_starve >= LIM) && if_req_valid)) g_dm = 1'b1;
      else if (if_req_valid) g_if = 1'b1;
    end
    chk("if_req_ready", if_req_ready, g_if);
    chk("dm_req_ready", dm_req_ready, g_dm);
    chk("bus_req_valid", bus_req_valid, m_busy && !m_hs);
    if (m_busy && !m_hs) begin
      chk("bus_req_addr", bus_req_addr, m_addr);
      chk("bus_req_we", bus_req_we, m_we);
      chk("bus_req_wstrb", bus_req_wstrb, m_wstrb);
      if (m_own_dm) chk("bus_req_wdata", bus_req_wdata, m_wdata);
    end
    chk("if_rsp_valid", if_rsp_valid, e_if_p);
    chk("dm_rsp_valid", dm_rsp_valid, e_dm_p);
    if (e_if_p) chk("if_rsp_data", if_rsp_data, e_if_d);
    if (e_dm_p) chk("dm_rsp_data", dm_rsp_data, e_dm_d);
    if (dm_req_ready) q_gnt.push_back(8'h44);
    if (if_req_ready) q_gnt.push_back(8'h49);

    e_if_p = 1'b0;
    e_dm_p = 1'b0;
    if (m_busy && m_hs && bus_rsp_valid) begin
      m_busy = 1'b0;
      if (m_own_dm) begin e_dm_p = 1'b1; e_dm_d = m_we ? 32'h0 : bus_rsp_data; end
      else          begin e_if_p = 1'b1; e_if_d = bus_rsp_data; end
    end else if (m_busy && !m_hs && bus_req_ready) begin
      m_hs = 1'b1;
    end
    if (g_dm) begin
      m_busy = 1'b1; m_hs = 1'b0; m_own_dm = 1'b1;
      m_addr = dm_req_addr; m_we = dm_req_we; m_wdata = dm_req_wdata; m_wstrb = dm_req_wstrb;
      if (if_req_valid) m_starve++;
    end else if (g_if) begin
      m_busy = 1'b1; m_hs = 1'b0; m_own_dm = 1'b0;
      m_addr = if_req_addr; m_we = 1'b0; m_wdata = 32'h0; m_wstrb = 4'h0;
      m_starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_s;
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_req_addr = 32'h0;
    dm_req_valid = 1'b0; dm_req_addr = 32'h0; dm_req_we = 1'b0;
    dm_req_wdata = 32'h0; dm_req_wstrb = 4'h0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req_valid", bus_req_valid, 1'b0);
    chk("rst_bus_req_addr", bus_req_addr, 32'h0);
    chk("rst_if_rsp_valid", if_rsp_valid, 1'b0);
    chk("rst_dm_rsp_valid", dm_rsp_valid, 1'b0);
    rst_n = 1'b1;
    step();

    // Fetch only, zero-wait bus, response two cycles after acceptance.
    if_req_valid = 1'b1; if_req_addr = 32'h100; bus_req_ready = 1'b1;
    #2 chk("t1_if_ready_c0", if_req_ready, 1'b1);
    step();
    if_req_valid = 1'b0;
    #2 chk("t1_bus_valid_c1", bus_req_valid, 1'b1);
    chk("t1_bus_addr_c1", bus_req_addr, 32'h100);
    chk("t1_bus_wstrb_c1", bus_req_wstrb, 4'h0);
    step();
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h0050_0093;
    step();
    bus_rsp_valid = 1'b0;
    #2 chk("t1_if_rsp_valid_c3", if_rsp_valid, 1'b1);
    chk("t1_if_rsp_data_c3", if_rsp_data, 32'h0050_0093);
    chk("t1_dm_rsp_valid_c3", dm_rsp_valid, 1'b0);
    step();

    // Fetch and load together: load first, fetch accepted on the load's response pulse.
    if_req_valid = 1'b1; if_req_addr = 32'h300;
    dm_req_valid = 1'b1; dm_req_addr = 32'h2000; dm_req_we = 1'b0;
    #2 chk("t2_dm_ready", dm_req_ready, 1'b1);
    chk("t2_if_ready", if_req_ready, 1'b0);
    step();
    dm_req_valid = 1'b0;
    step();
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'hDEAD_BEEF;
    step();
    bus_rsp_valid = 1'b0;
    #2 chk("t2_dm_rsp_valid", dm_rsp_valid, 1'b1);
    chk("t2_dm_rsp_data", dm_rsp_data, 32'hDEAD_BEEF);
    chk("t2_if_ready_overlap", if_req_ready, 1'b1);
    step();
    if_req_valid = 1'b0;
    step();
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h0000_0013;
    step();
    bus_rsp_valid = 1'b0;
    step();

    // Store with the bus stalling three cycles.
    dm_req_valid = 1'b1; dm_req_addr = 32'h40; dm_req_we = 1'b1;
    dm_req_wdata = 32'h1122_3344; dm_req_wstrb = 4'h3; bus_req_ready = 1'b0;
    step();
    dm_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #2 chk("t3_bus_wdata", bus_req_wdata, 32'h1122_3344);
    chk("t3_bus_wstrb", bus_req_wstrb, 4'h3);
    chk("t3_bus_we", bus_req_we, 1'b1);
    bus_req_ready = 1'b1;
    step();
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'hFFFF_FFFF;
    step();
    bus_rsp_valid = 1'b0;
    #2 chk("t3_dm_rsp_valid", dm_rsp_valid, 1'b1);
    chk("t3_dm_rsp_data", dm_rsp_data, 32'h0);
    step();

    // Spurious response while idle.
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'hA5A5_A5A5;
    step(); step();
    bus_rsp_valid = 1'b0;
    #2 chk("t4_no_if_pulse", if_rsp_valid, 1'b0);
    chk("t4_no_dm_pulse", dm_rsp_valid, 1'b0);
    step();

    // Reset while waiting for the response.
    if_req_valid = 1'b1; if_req_addr = 32'h500;
    step();
    if_req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1 chk("t5_bus_valid", bus_req_valid, 1'b0);
    chk("t5_bus_addr", bus_req_addr, 32'h0);
    chk("t5_if_rsp_data", if_rsp_data, 32'h0);
    chk("t5_dm_rsp_data", dm_rsp_data, 32'h0);
    model_reset();
    step();
    rst_n = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_data = 32'h1234_5678;
    step();
    bus_rsp_valid = 1'b0;
    step();
    #2 chk("t5_no_if_pulse", if_rsp_valid, 1'b0);
    step();

    // Both requesters continuously valid, instant bus.
    q_gnt.delete();
    if_req_valid = 1'b1; if_req_addr = 32'h600;
    dm_req_valid = 1'b1; dm_req_addr = 32'h700; dm_req_we = 1'b0;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_data = 32'h0BAD_F00D;
    for (int i = 0; i < 18; i++) step();
    if_req_valid = 1'b0; dm_req_valid = 1'b0; bus_rsp_valid = 1'b0;
    repeat (3) step();
    exp_s = GUARD ? "DDIDDI" : "DDDDDD";
    chk("t6_gnt_count", q_gnt.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i < q_gnt.size()) chk($sformatf("t6_gnt_%0d", i), q_gnt[i], exp_s[i]);
    end

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if (if_req_valid && !g_if && ($urandom_range(0, 99) >= 3)) begin
        if_req_valid = 1'b1;
      end else begin
        if_req_valid = $urandom_range(0, 1) == 1;
        if_req_addr  = $urandom;
      end
      if (dm_req_valid && !g_dm && ($urandom_range(0, 99) >= 3)) begin
        dm_req_valid = 1'b1;
      end else begin
        dm_req_valid = $urandom_range(0, 1) == 1;
        dm_req_addr  = $urandom;
        dm_req_we    = $urandom_range(0, 1) == 1;
        dm_req_wdata = $urandom;
        dm_req_wstrb = 4'($urandom_range(0, 15));
      end
      bus_req_ready = $urandom_range(0, 1) == 1;
      bus_rsp_valid = $urandom_range(0, 99) < 40;
      bus_rsp_data  = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
